aes_enc_rr_arbiter: RTL and testbench
=====================================

Name: aes_enc_rr_arbiter

Overview:
Shares one AES encipher round engine between NUM_REQ independent block requesters. Round-robin arbitration picks a requester, latches its plaintext, pulses `next` to the engine, tracks the engine's ready handshake, captures the result and returns it tagged with the requester ID. It also drives a trigger for side-channel capture and a watchdog for a hung engine. It sits between the requester-facing bus logic and the encipher/key-expansion/sbox core, which shares clk and reset_n.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
TIMEOUT, 63, maximum engine busy cycles before abort (6-bit counter, 1..63).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_block  in  NUM_REQ*128  per-requester plaintext; requester r uses [r*128 +: 128]
req_ready  out  NUM_REQ  one-hot accept strobe
resp_valid  out  1  result available
resp_id  out  ID_W  requester that owns the result
resp_block  out  128  ciphertext, or 0 on error
resp_err  out  1  the response is a timeout abort
resp_ready  in  1  consumer accepts the response
core_next  out  1  start pulse to the engine
core_block  out  128  plaintext to the engine, held stable for the whole operation
core_ready  in  1  engine idle/done
core_result  in  128  engine output block
trig  out  1  scope trigger, high while the engine is busy for this block
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer 0; latched block/id 0; err_timeout 0.
- Engine contract:
  - core_ready falls the cycle after the core_next cycle.
  - With a 128-bit key, core_ready rises 11 cycles later.
  - core_result is valid while core_ready=1.
- FSM states: IDLE, START, WAIT_LOW, WAIT_DONE, RESP.
- IDLE:
  - If core_ready=1 and any req_valid: grant g = first set req_valid searching ptr, ptr+1, ... with wrap mod NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational, single cycle); latch req_block[g] into blk_reg and g into id_reg; go to START.
  - If core_ready=0 in IDLE: no grant.
- START: core_next=1 for exactly this cycle; trig=1; watchdog cleared; go to WAIT_LOW.
- WAIT_LOW: trig=1. On core_ready=0, go to WAIT_DONE.
- WAIT_DONE: trig=1. On core_ready=1, capture core_result into resp_block, set resp_err=0, go to RESP.
- Watchdog:
  - Counts each cycle spent in WAIT_LOW or WAIT_DONE.
  - When count == TIMEOUT and the exit condition is not met: set err_timeout (sticky until reset), resp_block=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid=1; resp_id/resp_block/resp_err held stable until resp_ready.
  - On resp_valid & resp_ready: ptr = (id_reg+1) mod NUM_REQ; go to IDLE.
- core_block = blk_reg at all times; it is unchanged from START until the next grant.
- Only one operation is in flight at a time. New requests are not accepted in START through RESP; requesters hold req_valid/req_block until req_ready.
- Latency: req_ready cycle T → core_next T+1 → resp_valid T+14 (128-bit key, nominal engine). Back-to-back requests from a different requester are granted the cycle after the resp handshake.
- busy = (state != IDLE).
- Reset asserted mid-operation: immediate return to reset values; the in-flight request is dropped with no response.

Test Plan:
1. Single request: req_valid=0001, block 00112233445566778899aabbccddeeff, engine keyed with 000102…0f → req_ready=0001; core_next one cycle later; resp_valid 14 cycles after req_ready; resp_block 69c4e0d86a7b0430d8cdb78070b4c55a; resp_id=0.
2. Fairness: all four req_valid held high for 8 operations → grant order 0,1,2,3,0,1,2,3; never two req_ready bits set in one cycle.
3. Backpressure: resp_ready=0 for 20 cycles → resp_valid/resp_block/resp_id stable; no new req_ready; after resp_ready=1 the next grant follows 1 cycle after the handshake.
4. Watchdog: engine model keeps core_ready=0 forever → after 63 busy cycles resp_valid=1, resp_err=1, resp_block=0, err_timeout=1 and stays 1 across later good operations.
5. Engine not idle: core_ready=0 while in IDLE with req_valid=0010 → no req_ready until core_ready=1.
6. Reset mid-operation: reset_n low during WAIT_DONE → all outputs 0 asynchronously; after release, a fresh request completes normally with ptr restarting at 0.

Source files
------------

// File: rtl/aes_enc_rr_arbiter.sv
// aes_enc_rr_arbiter
// Shares one AES encipher round engine between NUM_REQ requesters. A round-robin
// search picks a requester, latches its plaintext, pulses core_next, follows the
// engine's ready handshake and returns the ciphertext tagged with the requester ID.
// A watchdog aborts an operation if the engine stays busy too long.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_block     per-requester request and plaintext ([r*128 +: 128])
//   req_ready               one-hot, single-cycle accept strobe
//   resp_valid/resp_id/...  response channel, held until resp_ready
//   core_next/core_block    start pulse and plaintext to the engine
//   core_ready/core_result  engine idle/done flag and output block
//   trig                    high while the engine works on our block
//   busy                    FSM not idle
//   err_timeout             sticky watchdog flag
module aes_enc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_block,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [127:0]           resp_block,
    output logic                   resp_err,
    input  logic                   resp_ready,
    output logic                   core_next,
    output logic [127:0]           core_block,
    input  logic                   core_ready,
    input  logic [127:0]           core_result,
    output logic                   trig,
    output logic                   busy,
    output logic                   err_timeout
);

    typedef enum logic [2:0] {StIdle, StStart, StWaitLow, StWaitDone, StResp} state_e;

    // Watchdog fires on the TIMEOUT-th wait cycle (counter holds cycles already spent).
    localparam logic [5:0]    WdogLast = 6'(TIMEOUT - 1);
    localparam logic [ID_W:0] NumReqW  = (ID_W + 1)'(NUM_REQ);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [127:0]    blk_q, blk_d;
    logic [127:0]    resp_block_q, resp_block_d;
    logic            resp_err_q, resp_err_d;
    logic [5:0]      wdog_q, wdog_d;
    logic            err_timeout_q, err_timeout_d;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;

    // Round-robin search: first valid requester at ptr, ptr+1, ... modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] cand;
        gnt_found = 1'b0;
        gnt_id    = ptr_q;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        logic [ID_W:0] ptr_inc;
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        blk_d         = blk_q;
        resp_block_d  = resp_block_q;
        resp_err_d    = resp_err_q;
        wdog_d        = wdog_q;
        err_timeout_d = err_timeout_q;
        req_ready     = '0;
        ptr_inc       = {1'b0, id_q} + 1'b1;

        unique case (state_q)
            StIdle: begin
                // Gated by reset_n so req_ready stays low while reset is held.
                if (reset_n && core_ready && gnt_found) begin
                    req_ready[gnt_id] = 1'b1;
                    blk_d             = req_block[{gnt_id, 7'd0} +: 128];
                    id_d              = gnt_id;
                    state_d           = StStart;
                end
            end
            StStart: begin
                wdog_d  = '0;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                wdog_d = wdog_q + 6'd1;
                if (!core_ready) begin
                    state_d = StWaitDone;
                end else if (wdog_q == WdogLast) begin
                    err_timeout_d = 1'b1;
                    resp_block_d  = '0;
                    resp_err_d    = 1'b1;
                    state_d       = StResp;
                end
            end
            StWaitDone: begin
                wdog_d = wdog_q + 6'd1;
                if (core_ready) begin
                    resp_block_d = core_result;
                    resp_err_d   = 1'b0;
                    state_d      = StResp;
                end else if (wdog_q == WdogLast) begin
                    err_timeout_d = 1'b1;
                    resp_block_d  = '0;
                    resp_err_d    = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    ptr_d   = (ptr_inc == NumReqW) ? '0 : ptr_inc[ID_W-1:0];
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            id_q          <= '0;
            blk_q         <= '0;
            resp_block_q  <= '0;
            resp_err_q    <= 1'b0;
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            blk_q         <= blk_d;
            resp_block_q  <= resp_block_d;
            resp_err_q    <= resp_err_d;
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign resp_valid  = (state_q == StResp);
    assign resp_id     = id_q;
    assign resp_block  = resp_block_q;
    assign resp_err    = resp_err_q;
    assign core_next   = (state_q == StStart);
    assign core_block  = blk_q;
    assign trig        = (state_q == StStart) || (state_q == StWaitLow) ||
                         (state_q == StWaitDone);
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_aes_enc_rr_arbiter.sv
// Directed bench for aes_enc_rr_arbiter with a behavioural engine model.
module tb_aes_enc_rr_arbiter;

    localparam logic [127:0] Pt0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Pt1   = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] Pt2   = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [127:0] Pt3   = 128'h303132333435363738393a3b3c3d3e3f;
    localparam logic [127:0] KMask = 128'hdeadbeef_0badf00d_cafebabe_12345678;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [511:0] req_block;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [127:0] resp_block;
    logic         resp_err;
    logic         resp_ready;
    logic         core_next;
    logic [127:0] core_block;
    logic         core_ready;
    logic [127:0] core_result;
    logic         trig;
    logic         busy;
    logic         err_timeout;

    int errors = 0;
    int checks = 0;

    // Engine model: ready drops after core_next, rises 11 cycles later.
    logic [3:0] eng_cnt;
    logic       eng_rdy;
    logic       eng_stuck;
    logic       eng_hold;

    aes_enc_rr_arbiter #(
        .NUM_REQ(4),
        .ID_W   (2),
        .TIMEOUT(63)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_block  (req_block),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_block (resp_block),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .core_next  (core_next),
        .core_block (core_block),
        .core_ready (core_ready),
        .core_result(core_result),
        .trig       (trig),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_cnt <= 4'd0;
            eng_rdy <= 1'b1;
        end else if (core_next) begin
            eng_cnt <= 4'd11;
            eng_rdy <= 1'b0;
        end else if (eng_cnt > 4'd1) begin
            eng_cnt <= eng_cnt - 4'd1;
        end else if (!eng_stuck) begin
            eng_cnt <= 4'd0;
            eng_rdy <= 1'b1;
        end
    end

    assign core_ready  = eng_rdy & ~eng_hold;
    assign core_result = (core_block == Pt0) ? Ct0 : (core_block ^ KMask);

    function automatic logic [127:0] pt_of(input int r);
        case (r)
            0:       return Pt0;
            1:       return Pt1;
            2:       return Pt2;
            default: return Pt3;
        endcase
    endfunction

    function automatic logic [127:0] ct_of(input int r);
        return (r == 0) ? Ct0 : (pt_of(r) ^ KMask);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with req_valid already set; the grant is expected this cycle.
    // Returns at the first cycle with resp_valid (or when the bound expires).
    task automatic run_op(input int id, input logic [127:0] exp_blk, input logic exp_err,
                          input int exp_lat, input bit drop);
        int n;
        #1;
        chk("grant", 128'(req_ready), 128'(1) << id);
        n = 0;
        @(negedge clk);
        #1;
        n = 1;
        if (drop) req_valid[id] = 1'b0;
        chk("core_next_pulse", 128'(core_next), 128'(1));
        chk("core_block", core_block, pt_of(id));
        chk("trig_start", 128'(trig), 128'(1));
        while (resp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 2) chk("core_next_once", 128'(core_next), 128'(0));
        end
        chk("latency", 128'(n), 128'(exp_lat));
        chk("resp_id", 128'(resp_id), 128'(id));
        chk("resp_block", resp_block, exp_blk);
        chk("resp_err", 128'(resp_err), 128'(exp_err));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 4'b0000;
        req_block  = {Pt3, Pt2, Pt1, Pt0};
        resp_ready = 1'b1;
        eng_stuck  = 1'b0;
        eng_hold   = 1'b0;

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_trig", 128'(trig), 128'(0));
        chk("rst_core_next", 128'(core_next), 128'(0));
        chk("rst_core_block", core_block, 128'(0));
        chk("rst_err_timeout", 128'(err_timeout), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Single request, FIPS-197 vector
        @(negedge clk);
        req_valid = 4'b0001;
        run_op(0, Ct0, 1'b0, 14, 1'b1);
        @(negedge clk);
        #1;
        chk("idle_after_hs", 128'(busy), 128'(0));

        // Fairness from a fresh pointer
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            run_op(k % 4, ct_of(k % 4), 1'b0, 14, 1'b0);
            if (k == 7) req_valid = 4'b0000;
            @(negedge clk);
        end

        // Backpressure: response held, no new grant; ptr is 0
        resp_ready = 1'b0;
        req_valid  = 4'b0110;
        run_op(1, ct_of(1), 1'b0, 14, 1'b1);
        repeat (20) begin
            @(negedge clk);
            #1;
            chk("bp_valid", 128'(resp_valid), 128'(1));
            chk("bp_block", resp_block, ct_of(1));
            chk("bp_id", 128'(resp_id), 128'(1));
            chk("bp_no_grant", 128'(req_ready), 128'(0));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        run_op(2, ct_of(2), 1'b0, 14, 1'b1);
        @(negedge clk);

        // Watchdog: engine never finishes; ptr is 3 so requester 0 wins
        eng_stuck = 1'b1;
        req_valid = 4'b0001;
        run_op(0, 128'(0), 1'b1, 65, 1'b1);
        chk("wdog_flag", 128'(err_timeout), 128'(1));
        eng_stuck = 1'b0;
        @(negedge clk);
        req_valid = 4'b1000;
        run_op(3, ct_of(3), 1'b0, 14, 1'b1);
        chk("wdog_sticky", 128'(err_timeout), 128'(1));
        @(negedge clk);

        // Engine not idle: no grant until core_ready returns
        eng_hold  = 1'b1;
        req_valid = 4'b0010;
        repeat (5) begin
            #1;
            chk("hold_no_grant", 128'(req_ready), 128'(0));
            chk("hold_idle", 128'(busy), 128'(0));
            @(negedge clk);
        end
        eng_hold = 1'b0;
        run_op(1, ct_of(1), 1'b0, 14, 1'b1);
        @(negedge clk);

        // Reset during WAIT_DONE; ptr is 2 before reset
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 128'(req_ready), 128'(4'b0100));
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_trig", 128'(trig), 128'(1));
        reset_n   = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("mr_busy", 128'(busy), 128'(0));
        chk("mr_trig", 128'(trig), 128'(0));
        chk("mr_core_block", core_block, 128'(0));
        chk("mr_resp_valid", 128'(resp_valid), 128'(0));
        chk("mr_req_ready", 128'(req_ready), 128'(0));
        chk("mr_err_timeout", 128'(err_timeout), 128'(0));
        chk("mr_resp_block", resp_block, 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_op(0, Ct0, 1'b0, 14, 1'b1);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        chk("final_idle", 128'(busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
